// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the ARM-subset datapath: fetch/decode/execute/writeback,
// load/store memory states with a request/ready handshake and timeout fault, and branch.
module multicycle_ctrl_fsm #(
    parameter int                  ALU_OP_W    = 4,
    parameter int                  SHIFT_OP_W  = 3,
    parameter logic [ALU_OP_W-1:0] ALU_ADD     = 4'b0100,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  isCondSatisfy,
    input  logic [1:0]            instr_class,
    input  logic                  TTCC,
    input  logic                  rm_imm_s,
    input  logic [1:0]            rs_imm_s,
    input  logic [SHIFT_OP_W-1:0] Shift_OP,
    input  logic [ALU_OP_W-1:0]   ALU_OP,
    input  logic                  S,
    input  logic                  mem_ready,
    output logic                  W_PC_EN,
    output logic                  W_IR_EN,
    output logic                  W_Reg,
    output logic                  LA,
    output logic                  LB,
    output logic                  LC,
    output logic                  LF,
    output logic                  LD,
    output logic                  S_ctrl,
    output logic                  rm_imm_s_ctrl,
    output logic [1:0]            rs_imm_s_ctrl,
    output logic [SHIFT_OP_W-1:0] shift_OP_ctrl,
    output logic [ALU_OP_W-1:0]   ALU_OP_ctrl,
    output logic                  Mem_Req,
    output logic                  Mem_Write,
    output logic                  Reg_Src_Mem,
    output logic                  PC_Src_ALU,
    output logic                  mem_fault,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        WB     = 4'd4,
        MADDR  = 4'd5,
        MREAD  = 4'd6,
        MWRITE = 4'd7,
        MWB    = 4'd8,
        BR     = 4'd9,
        FAULT  = 4'd15
    } state_e;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e                 st_q, st_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic                   w_pc_en_q, w_pc_en_d;
    logic                   w_reg_q, w_reg_d;
    logic                   la_q, la_d;
    logic                   lb_q, lb_d;
    logic                   lc_q, lc_d;
    logic                   lf_q, lf_d;
    logic                   s_ctrl_q, s_ctrl_d;
    logic                   rm_imm_s_ctrl_q, rm_imm_s_ctrl_d;
    logic [1:0]             rs_imm_s_ctrl_q, rs_imm_s_ctrl_d;
    logic [SHIFT_OP_W-1:0]  shift_op_ctrl_q, shift_op_ctrl_d;
    logic [ALU_OP_W-1:0]    alu_op_ctrl_q, alu_op_ctrl_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_write_q, mem_write_d;
    logic                   reg_src_mem_q, reg_src_mem_d;
    logic                   pc_src_alu_q, pc_src_alu_d;
    logic                   mem_fault_q, mem_fault_d;

    logic in_mem;
    logic timeout;

    assign in_mem  = (st_q == MREAD) || (st_q == MWRITE);
    // Fires on the last permitted non-ready cycle; a ready in that same cycle still completes.
    assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = FETCH;
            FETCH:   st_d = isCondSatisfy ? DECODE : FETCH;
            DECODE: begin
                case (instr_class)
                    2'b00:   st_d = EXEC;
                    2'b11:   st_d = BR;
                    default: st_d = MADDR;
                endcase
            end
            EXEC:    st_d = TTCC ? FETCH : WB;
            WB:      st_d = FETCH;
            MADDR:   st_d = (instr_class == 2'b10) ? MWRITE : MREAD;
            MREAD:   st_d = mem_ready ? MWB : (timeout ? FAULT : MREAD);
            MWRITE:  st_d = mem_ready ? FETCH : (timeout ? FAULT : MWRITE);
            MWB:     st_d = FETCH;
            BR:      st_d = FETCH;
            FAULT:   st_d = FAULT;
            default: st_d = FETCH;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (((st_d == MREAD) || (st_d == MWRITE)) && !in_mem) begin
            wait_cnt_d = '0;
        end else if (in_mem && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Enables are decoded from the upcoming state so they line up with state occupancy.
    always_comb begin
        w_pc_en_d       = 1'b0;
        w_reg_d         = 1'b0;
        la_d            = 1'b0;
        lb_d            = 1'b0;
        lc_d            = 1'b0;
        lf_d            = 1'b0;
        s_ctrl_d        = 1'b0;
        mem_req_d       = 1'b0;
        mem_write_d     = 1'b0;
        reg_src_mem_d   = 1'b0;
        pc_src_alu_d    = 1'b0;
        mem_fault_d     = 1'b0;
        rm_imm_s_ctrl_d = rm_imm_s_ctrl_q;
        rs_imm_s_ctrl_d = rs_imm_s_ctrl_q;
        shift_op_ctrl_d = shift_op_ctrl_q;
        alu_op_ctrl_d   = alu_op_ctrl_q;
        case (st_d)
            FETCH:  w_pc_en_d = 1'b1;
            DECODE: begin
                la_d = 1'b1;
                lb_d = 1'b1;
                lc_d = 1'b1;
            end
            EXEC: begin
                lf_d            = 1'b1;
                s_ctrl_d        = S;
                rm_imm_s_ctrl_d = rm_imm_s;
                rs_imm_s_ctrl_d = rs_imm_s;
                shift_op_ctrl_d = Shift_OP;
                alu_op_ctrl_d   = ALU_OP;
            end
            WB:     w_reg_d = 1'b1;
            MADDR: begin
                lf_d            = 1'b1;
                rm_imm_s_ctrl_d = rm_imm_s;
                rs_imm_s_ctrl_d = rs_imm_s;
                shift_op_ctrl_d = Shift_OP;
                alu_op_ctrl_d   = ALU_ADD;
            end
            MREAD:  mem_req_d = 1'b1;
            MWRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            MWB: begin
                w_reg_d       = 1'b1;
                reg_src_mem_d = 1'b1;
            end
            BR: begin
                w_pc_en_d     = 1'b1;
                pc_src_alu_d  = 1'b1;
                lf_d          = 1'b1;
                alu_op_ctrl_d = ALU_ADD;
            end
            FAULT:  mem_fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            st_q            <= IDLE;
            wait_cnt_q      <= '0;
            w_pc_en_q       <= 1'b0;
            w_reg_q         <= 1'b0;
            la_q            <= 1'b0;
            lb_q            <= 1'b0;
            lc_q            <= 1'b0;
            lf_q            <= 1'b0;
            s_ctrl_q        <= 1'b0;
            rm_imm_s_ctrl_q <= 1'b0;
            rs_imm_s_ctrl_q <= '0;
            shift_op_ctrl_q <= '0;
            alu_op_ctrl_q   <= '0;
            mem_req_q       <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_src_mem_q   <= 1'b0;
            pc_src_alu_q    <= 1'b0;
            mem_fault_q     <= 1'b0;
        end else begin
            st_q            <= st_d;
            wait_cnt_q      <= wait_cnt_d;
            w_pc_en_q       <= w_pc_en_d;
            w_reg_q         <= w_reg_d;
            la_q            <= la_d;
            lb_q            <= lb_d;
            lc_q            <= lc_d;
            lf_q            <= lf_d;
            s_ctrl_q        <= s_ctrl_d;
            rm_imm_s_ctrl_q <= rm_imm_s_ctrl_d;
            rs_imm_s_ctrl_q <= rs_imm_s_ctrl_d;
            shift_op_ctrl_q <= shift_op_ctrl_d;
            alu_op_ctrl_q   <= alu_op_ctrl_d;
            mem_req_q       <= mem_req_d;
            mem_write_q     <= mem_write_d;
            reg_src_mem_q   <= reg_src_mem_d;
            pc_src_alu_q    <= pc_src_alu_d;
            mem_fault_q     <= mem_fault_d;
        end
    end

    // IR loads in the very FETCH cycle whose condition passes, i.e. the one that leaves FETCH.
    assign W_IR_EN       = (st_q == FETCH) && isCondSatisfy;
    assign LD            = (st_q == MREAD) && mem_ready;
    assign W_PC_EN       = w_pc_en_q;
    assign W_Reg         = w_reg_q;
    assign LA            = la_q;
    assign LB            = lb_q;
    assign LC            = lc_q;
    assign LF            = lf_q;
    assign S_ctrl        = s_ctrl_q;
    assign rm_imm_s_ctrl = rm_imm_s_ctrl_q;
    assign rs_imm_s_ctrl = rs_imm_s_ctrl_q;
    assign shift_OP_ctrl = shift_op_ctrl_q;
    assign ALU_OP_ctrl   = alu_op_ctrl_q;
    assign Mem_Req       = mem_req_q;
    assign Mem_Write     = mem_write_q;
    assign Reg_Src_Mem   = reg_src_mem_q;
    assign PC_Src_ALU    = pc_src_alu_q;
    assign mem_fault     = mem_fault_q;
    assign state_o       = st_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level reference model checked every cycle,
// plus directed literal expectations along the test-plan scenarios.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 15;
    localparam logic [3:0] ADD_OP = 4'b0100;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       isCondSatisfy = 1'b0;
    logic [1:0] instr_class = 2'b00;
    logic       TTCC = 1'b0;
    logic       rm_imm_s = 1'b0;
    logic [1:0] rs_imm_s = 2'b00;
    logic [2:0] Shift_OP = 3'd0;
    logic [3:0] ALU_OP = 4'd0;
    logic       S = 1'b0;
    logic       mem_ready = 1'b0;

    logic       W_PC_EN, W_IR_EN, W_Reg, LA, LB, LC, LF, LD, S_ctrl;
    logic       rm_imm_s_ctrl;
    logic [1:0] rs_imm_s_ctrl;
    logic [2:0] shift_OP_ctrl;
    logic [3:0] ALU_OP_ctrl;
    logic       Mem_Req, Mem_Write, Reg_Src_Mem, PC_Src_ALU, mem_fault;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .ALU_OP_W(4), .SHIFT_OP_W(3), .ALU_ADD(ADD_OP), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .Rst(Rst), .isCondSatisfy(isCondSatisfy), .instr_class(instr_class),
        .TTCC(TTCC), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .Shift_OP(Shift_OP),
        .ALU_OP(ALU_OP), .S(S), .mem_ready(mem_ready),
        .W_PC_EN(W_PC_EN), .W_IR_EN(W_IR_EN), .W_Reg(W_Reg), .LA(LA), .LB(LB), .LC(LC),
        .LF(LF), .LD(LD), .S_ctrl(S_ctrl), .rm_imm_s_ctrl(rm_imm_s_ctrl),
        .rs_imm_s_ctrl(rs_imm_s_ctrl), .shift_OP_ctrl(shift_OP_ctrl), .ALU_OP_ctrl(ALU_OP_ctrl),
        .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Reg_Src_Mem(Reg_Src_Mem),
        .PC_Src_ALU(PC_Src_ALU), .mem_fault(mem_fault), .state_o(state_o)
    );

    // Reference model: which phase the instruction is in and how long memory has stalled.
    int         m_st = 0;
    int         m_wait = 0;
    logic       m_rm = 1'b0;
    logic [1:0] m_rs = 2'b00;
    logic [2:0] m_sh = 3'd0;
    logic [3:0] m_alu = 4'd0;
    logic       m_s = 1'b0;

    function automatic int model_next(int st, int waited);
        case (st)
            0: return 1;
            1: return isCondSatisfy ? 2 : 1;
            2: return (instr_class == 2'b00) ? 3 : ((instr_class == 2'b11) ? 9 : 5);
            3: return TTCC ? 1 : 4;
            5: return (instr_class == 2'b10) ? 7 : 6;
            6, 7: begin
                if (mem_ready) return (st == 6) ? 8 : 1;
                if (TO > 0 && waited + 1 == TO) return 15;
                return st;
            end
            15: return 15;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk or posedge Rst) begin
        if (Rst) begin
            m_st <= 0; m_wait <= 0; m_rm <= 1'b0; m_rs <= 2'b00;
            m_sh <= 3'd0; m_alu <= 4'd0; m_s <= 1'b0;
        end else begin
            m_st   <= model_next(m_st, m_wait);
            m_wait <= (m_st == 6 || m_st == 7) ? m_wait + 1 : 0;
            case (model_next(m_st, m_wait))
                3: begin
                    m_rm <= rm_imm_s; m_rs <= rs_imm_s; m_sh <= Shift_OP;
                    m_alu <= ALU_OP; m_s <= S;
                end
                5: begin
                    m_rm <= rm_imm_s; m_rs <= rs_imm_s; m_sh <= Shift_OP; m_alu <= ADD_OP;
                end
                9: m_alu <= ADD_OP;
                default: ;
            endcase
        end
    end

    function automatic logic [27:0] expected_vec();
        logic [13:0] p;
        p = { (m_st == 1 || m_st == 9),          // W_PC_EN
              (m_st == 1 && isCondSatisfy),      // W_IR_EN
              (m_st == 4 || m_st == 8),          // W_Reg
              (m_st == 2), (m_st == 2), (m_st == 2),
              (m_st == 3 || m_st == 5 || m_st == 9),
              (m_st == 6 && mem_ready),          // LD
              (m_st == 3 && m_s),
              (m_st == 6 || m_st == 7),
              (m_st == 7),
              (m_st == 8),
              (m_st == 9),
              (m_st == 15) };
        return {p, m_rm, m_rs, m_sh, m_alu, 4'(m_st)};
    endfunction

    always @(negedge clk) begin
        logic [27:0] act;
        logic [27:0] exp_v;
        act = {W_PC_EN, W_IR_EN, W_Reg, LA, LB, LC, LF, LD, S_ctrl, Mem_Req, Mem_Write,
               Reg_Src_Mem, PC_Src_ALU, mem_fault, rm_imm_s_ctrl, rs_imm_s_ctrl,
               shift_OP_ctrl, ALU_OP_ctrl, state_o};
        exp_v = expected_vec();
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act, exp_v);
        end
    end

    task automatic lit(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        lit("reset_state", state_o, 0);
        lit("reset_mem_req", Mem_Req, 0);
        lit("reset_fault", mem_fault, 0);
        lit("reset_alu_ctrl", ALU_OP_ctrl, 0);
        lit("reset_pc_en", W_PC_EN, 0);

        // Data-processing instruction with writeback
        isCondSatisfy = 1'b1; instr_class = 2'b00; ALU_OP = 4'b0100; S = 1'b1;
        rm_imm_s = 1'b1; rs_imm_s = 2'b10; Shift_OP = 3'd5;
        Rst = 1'b0;
        cyc(); lit("dp_fetch", state_o, 1); lit("dp_ir_en", W_IR_EN, 1);
        cyc(); lit("dp_decode", state_o, 2); lit("dp_la", LA, 1);
        cyc(); lit("dp_exec", state_o, 3); lit("dp_lf", LF, 1); lit("dp_s_ctrl", S_ctrl, 1);
        lit("dp_alu_ctrl", ALU_OP_ctrl, 4); lit("dp_shift_ctrl", shift_OP_ctrl, 5);
        lit("dp_exec_wreg", W_Reg, 0);
        cyc(); lit("dp_wb", state_o, 4); lit("dp_wb_wreg", W_Reg, 1);
        cyc(); lit("dp_back_fetch", state_o, 1); lit("dp_fetch_wreg", W_Reg, 0);

        // Condition fails for three FETCH cycles
        isCondSatisfy = 1'b0; #1;
        lit("cond_ir_en_1", W_IR_EN, 0); lit("cond_pc_en_1", W_PC_EN, 1);
        cyc(); lit("cond_hold_2", state_o, 1); lit("cond_ir_en_2", W_IR_EN, 0);
        cyc(); lit("cond_hold_3", state_o, 1); lit("cond_ir_en_3", W_IR_EN, 0);
        isCondSatisfy = 1'b1; #1;
        lit("cond_ir_en_4", W_IR_EN, 1); lit("cond_state_4", state_o, 1);
        cyc(); lit("cond_decode", state_o, 2);

        // Compare instruction: no writeback
        TTCC = 1'b1; ALU_OP = 4'b0011; S = 1'b0;
        cyc(); lit("ttcc_exec", state_o, 3); lit("ttcc_alu_ctrl", ALU_OP_ctrl, 3);
        lit("ttcc_wreg_exec", W_Reg, 0);
        cyc(); lit("ttcc_fetch", state_o, 1); lit("ttcc_wreg_fetch", W_Reg, 0);

        // LDR with three wait cycles
        TTCC = 1'b0; instr_class = 2'b01; ALU_OP = 4'b1010;
        cyc(); lit("ldr_decode", state_o, 2);
        cyc(); lit("ldr_maddr", state_o, 5); lit("ldr_add_forced", ALU_OP_ctrl, 4);
        lit("ldr_maddr_lf", LF, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); lit("ldr_wait_state", state_o, 6); lit("ldr_wait_req", Mem_Req, 1);
            lit("ldr_wait_ld", LD, 0); lit("ldr_wait_wr", Mem_Write, 0);
        end
        cyc(); lit("ldr_ready_state", state_o, 6);
        mem_ready = 1'b1; #1; lit("ldr_ld", LD, 1); lit("ldr_ready_req", Mem_Req, 1);
        cyc(); lit("ldr_mwb", state_o, 8); lit("ldr_mwb_wreg", W_Reg, 1);
        lit("ldr_mwb_src", Reg_Src_Mem, 1); lit("ldr_mwb_req", Mem_Req, 0);
        mem_ready = 1'b0;
        cyc(); lit("ldr_fetch", state_o, 1);

        // Branch
        instr_class = 2'b11;
        cyc(); lit("br_decode", state_o, 2);
        cyc(); lit("br_state", state_o, 9); lit("br_pc_en", W_PC_EN, 1);
        lit("br_pc_src", PC_Src_ALU, 1); lit("br_alu_add", ALU_OP_ctrl, 4);
        cyc(); lit("br_fetch", state_o, 1); lit("br_pc_src_off", PC_Src_ALU, 0);

        // STR that never completes: exactly TO cycles in MWRITE, then FAULT
        instr_class = 2'b10;
        cyc(); lit("str_decode", state_o, 2);
        cyc(); lit("str_maddr", state_o, 5);
        for (int i = 0; i < TO; i++) begin
            cyc(); lit("str_mwrite", state_o, 7); lit("str_wr", Mem_Write, 1);
        end
        cyc(); lit("str_fault", state_o, 15); lit("str_fault_flag", mem_fault, 1);
        lit("str_fault_req", Mem_Req, 0);
        instr_class = 2'b00;
        cyc(); lit("str_fault_sticky", state_o, 15); lit("str_fault_flag2", mem_fault, 1);
        Rst = 1'b1; #1;
        lit("str_rst_fault", mem_fault, 0); lit("str_rst_state", state_o, 0);
        cyc();
        instr_class = 2'b01; Rst = 1'b0;

        // LDR whose ready arrives in the timeout cycle completes normally
        cyc(); lit("edge_fetch", state_o, 1);
        cyc(); lit("edge_decode", state_o, 2);
        cyc(); lit("edge_maddr", state_o, 5);
        for (int i = 0; i < TO - 1; i++) begin
            cyc(); lit("edge_wait", state_o, 6);
        end
        cyc(); lit("edge_last", state_o, 6);
        mem_ready = 1'b1; #1; lit("edge_ld", LD, 1);
        cyc(); lit("edge_mwb", state_o, 8); lit("edge_no_fault", mem_fault, 0);
        mem_ready = 1'b0;
        cyc(); lit("edge_fetch2", state_o, 1);

        // Asynchronous reset in the middle of MREAD
        cyc(); lit("arst_decode", state_o, 2);
        cyc(); lit("arst_maddr", state_o, 5);
        cyc(); lit("arst_mread", state_o, 6); lit("arst_req_before", Mem_Req, 1);
        #1; Rst = 1'b1; #1;
        lit("arst_req_dropped", Mem_Req, 0); lit("arst_state", state_o, 0);
        cyc();
        Rst = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
